// File: rtl/gpio_pkg.sv
// gpio_pkg
// Shared definitions for the GPIO header controller: the register address
// type and the address of every register in the map.
// No ports (package).
package gpio_pkg;

  // Register select carried on the Address lines.
  typedef logic [2:0] gpio_addr_t;

  // Register map. Addresses 5..7 are unmapped: they read as zero and
  // writes to them are dropped.
  localparam gpio_addr_t GPIO_REG_DATA     = 3'd0;
  localparam gpio_addr_t GPIO_REG_DIR      = 3'd1;
  localparam gpio_addr_t GPIO_REG_IRQ_MASK = 3'd2;
  localparam gpio_addr_t GPIO_REG_EDGE_CAP = 3'd3;
  localparam gpio_addr_t GPIO_REG_DOUT_RB  = 3'd4;

endpackage

// File: rtl/gpio_port_ctrl_if.sv
// gpio_port_ctrl_if
// Single-master register bus between a processor/sequencer and the GPIO
// header controller.
//   Address   : register select (gpio_addr_t)
//   Write     : one-cycle write strobe, WriteData is captured with it
//   WriteData : WIDTH-bit write data
//   Read      : one-cycle read strobe
//   ReadData  : read result, holds until the next read completes
//   ReadValid : one-cycle pulse, the cycle after Read
// Modports: master (bus owner) and slave (the controller).
interface gpio_port_ctrl_if
  import gpio_pkg::*;
#(
  parameter int WIDTH = 32
);

  gpio_addr_t       Address;
  logic             Write;
  logic [WIDTH-1:0] WriteData;
  logic             Read;
  logic [WIDTH-1:0] ReadData;
  logic             ReadValid;

  modport master (
    output Address, Write, WriteData, Read,
    input  ReadData, ReadValid
  );

  modport slave (
    input  Address, Write, WriteData, Read,
    output ReadData, ReadValid
  );

endinterface

// File: rtl/gpio_sync_debounce.sv
// gpio_sync_debounce
// One header pin's input path: a two-flop synchronizer followed, when the
// GPIO_DEBOUNCE_EN macro is defined, by a stability filter. Without the
// macro the filtered output is simply the synchronized pin.
//   clk   : sole clock, rising edge
//   rst   : synchronous, active-high; clears synchronizer and filter
//   pin_i : raw, asynchronous pin level
//   din_o : synchronized (and optionally debounced) level
// Build option: GPIO_DEBOUNCE_EN enables the per-bit debounce counter.
module gpio_sync_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic din_o
);

  // A filter that needs zero stable cycles has no meaning; stop elaboration.
  if (DEBOUNCE_CYCLES < 1) begin : gBadDebounceLen
    $error("gpio_sync_debounce: DEBOUNCE_CYCLES must be at least 1");
  end

  logic meta_q;
  logic dinS_q;

  // Two-stage synchronizer; the first flop may go metastable, the second
  // gives it a full cycle to settle before anything else looks at it.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      dinS_q <= 1'b0;
    end else begin
      meta_q <= pin_i;
      dinS_q <= meta_q;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CntWidth = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DEBOUNCE_CYCLES - 1);

  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                dinF_q, dinF_d;

  // Count consecutive cycles in which the synchronized level disagrees with
  // the accepted level. On the DEBOUNCE_CYCLES-th disagreeing cycle the new
  // level is accepted; any agreeing cycle restarts the count from zero.
  always_comb begin
    cnt_d  = '0;
    dinF_d = dinF_q;
    if (dinS_q != dinF_q) begin
      if (cnt_q == CntLast) begin
        dinF_d = dinS_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      dinF_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dinF_q <= dinF_d;
    end
  end

  assign din_o = dinF_q;
`else
  assign din_o = dinS_q;
`endif

endmodule

// File: rtl/gpio_port_ctrl.sv
// gpio_port_ctrl
// Register-mapped controller for the 32-bit DE-series GPIO header. Owns the
// tri-state drive of each pin (direction + data-out registers), samples the
// pins through per-bit synchronizers, captures rising edges into sticky
// bits and raises a level interrupt for unmasked captures.
//   CLOCK_50 : sole clock, rising edge
//   Reset    : synchronous, active-high; clears all state, pins go Z
//   bus      : register bus (gpio_port_ctrl_if.slave)
//   IRQ      : registered level interrupt, |(EDGE_CAP & IRQ_MASK)
//   GPIO     : header pins, driven where DIR=1, Z elsewhere
// Register map: 0 DATA, 1 DIR, 2 IRQ_MASK, 3 EDGE_CAP (write-1-to-clear),
// 4 DOUT_RB, 5..7 read as zero.
// Build option: GPIO_DEBOUNCE_EN adds a DEBOUNCE_CYCLES stability filter
// to every input bit.
module gpio_port_ctrl
  import gpio_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   CLOCK_50,
  input  logic                   Reset,
  gpio_port_ctrl_if.slave        bus,
  output logic                   IRQ,
  inout  wire  [WIDTH-1:0]       GPIO
);

  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] readData_q, readData_d;
  logic             readValid_q;
  logic             irq_q;

  logic [WIDTH-1:0] dinF;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clearMask;
  logic [WIDTH-1:0] regValue;

  // One synchronizer/filter per pin. The pin is read straight off the
  // inout, so an output pin reads back its own driven level.
  for (genvar i = 0; i < WIDTH; i++) begin : gInput
    gpio_sync_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) uSyncDebounce (
      .clk   (CLOCK_50),
      .rst   (Reset),
      .pin_i (GPIO[i]),
      .din_o (dinF[i])
    );
  end

  // Drive only the pins configured as outputs; both registers change on the
  // same edge, so a pin switching to output drives the current dout at once.
  for (genvar i = 0; i < WIDTH; i++) begin : gDrive
    assign GPIO[i] = dir_q[i] ? dout_q[i] : 1'bz;
  end

  // Read mux. It looks only at registered state, so a read that shares a
  // cycle with a write returns the value from before that write.
  always_comb begin
    regValue = '0;
    case (bus.Address)
      GPIO_REG_DATA:     regValue = dinF;
      GPIO_REG_DIR:      regValue = dir_q;
      GPIO_REG_IRQ_MASK: regValue = mask_q;
      GPIO_REG_EDGE_CAP: regValue = cap_q;
      GPIO_REG_DOUT_RB:  regValue = dout_q;
      default:           regValue = '0;
    endcase
  end

  // Write decode, edge capture and read-data hold. In EDGE_CAP the fresh
  // rise is ORed in after the clear, so a clear and a new edge on the same
  // bit in the same cycle leaves the bit set.
  always_comb begin
    dout_d    = dout_q;
    dir_d     = dir_q;
    mask_d    = mask_q;
    clearMask = '0;
    if (bus.Write) begin
      case (bus.Address)
        GPIO_REG_DATA,
        GPIO_REG_DOUT_RB:  dout_d    = bus.WriteData;
        GPIO_REG_DIR:      dir_d     = bus.WriteData;
        GPIO_REG_IRQ_MASK: mask_d    = bus.WriteData;
        GPIO_REG_EDGE_CAP: clearMask = bus.WriteData;
        default:           clearMask = '0;
      endcase
    end
    rise       = dinF & ~prev_q;
    cap_d      = (cap_q & ~clearMask) | rise;
    readData_d = bus.Read ? regValue : readData_q;
  end

  // Register file and status state. Reset wins over any access in flight,
  // so a read issued together with reset never produces ReadValid. The
  // interrupt is computed from the registered capture/mask, which puts one
  // cycle between a capture and IRQ.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      dout_q      <= '0;
      dir_q       <= '0;
      mask_q      <= '0;
      cap_q       <= '0;
      prev_q      <= '0;
      readData_q  <= '0;
      readValid_q <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      dout_q      <= dout_d;
      dir_q       <= dir_d;
      mask_q      <= mask_d;
      cap_q       <= cap_d;
      prev_q      <= dinF;
      readData_q  <= readData_d;
      readValid_q <= bus.Read;
      irq_q       <= |(cap_q & mask_q);
    end
  end

  assign bus.ReadData  = readData_q;
  assign bus.ReadValid = readValid_q;
  assign IRQ           = irq_q;

endmodule

// File: tb/tb_gpio_port_ctrl.sv
// tb_gpio_port_ctrl
// Bench for gpio_port_ctrl. A time-indexed model predicts every output from
// the pin history and the register writes; directed sequences exercise the
// register map, pin drive, input sampling, edge capture, interrupt timing,
// collisions and reset. With GPIO_DEBOUNCE_EN defined only the debounce
// sequence runs.
module tb_gpio_port_ctrl;
  import gpio_pkg::*;

  localparam int WIDTH           = 32;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int LOG_SIZE        = 4096;

  logic             clock = 1'b0;
  logic             reset;
  logic             irq;
  wire  [WIDTH-1:0] gpio;
  logic [WIDTH-1:0] tbOut;
  logic [WIDTH-1:0] tbEn;

  int checks = 0;
  int errors = 0;

`ifdef GPIO_DEBOUNCE_EN
  localparam bit ModelOn = 1'b0;
`else
  localparam bit ModelOn = 1'b1;
`endif

  gpio_port_ctrl_if #(.WIDTH(WIDTH)) bus ();

  gpio_port_ctrl #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .CLOCK_50 (clock),
    .Reset    (reset),
    .bus      (bus),
    .IRQ      (irq),
    .GPIO     (gpio)
  );

  // The bench drives only the pins it has been told to own (tbEn).
  for (genvar i = 0; i < WIDTH; i++) begin : gTbDrive
    assign gpio[i] = tbEn[i] ? tbOut[i] : 1'bz;
  end

  always #5 clock = ~clock;

  // ---------------- model ----------------
  logic [WIDTH-1:0] mDout, mDir, mMask, mCap, mRdData;
  logic             mRdValid, mIrq;
  logic [WIDTH-1:0] pinLog [LOG_SIZE];
  int               edgeNo    = 0;
  int               resetEdge = 0;

  // Level on the pins: our own outputs where DIR=1, the bench elsewhere.
  function automatic logic [WIDTH-1:0] pinsNow();
    return (mDir & mDout) | (~mDir & tbEn & tbOut);
  endfunction

  // Filtered input level after edge k: the pin level seen at edge k-1,
  // once two edges have passed since reset (zero before that).
  function automatic logic [WIDTH-1:0] dinAfter(int k);
    if (k < resetEdge + 2) return '0;
    return pinLog[(k - 1) % LOG_SIZE];
  endfunction

  initial begin : modelProc
    logic [WIDTH-1:0] regVal, clr, riseNow;
    logic             irqNext;
    mDout = '0; mDir = '0; mMask = '0; mCap = '0;
    mRdData = '0; mRdValid = 1'b0; mIrq = 1'b0;
    forever begin
      @(posedge clock);
      pinLog[edgeNo % LOG_SIZE] = pinsNow();
      if (reset) begin
        mDout = '0; mDir = '0; mMask = '0; mCap = '0;
        mRdData = '0; mRdValid = 1'b0; mIrq = 1'b0;
        resetEdge = edgeNo;
      end else begin
        case (bus.Address)
          GPIO_REG_DATA:     regVal = dinAfter(edgeNo - 1);
          GPIO_REG_DIR:      regVal = mDir;
          GPIO_REG_IRQ_MASK: regVal = mMask;
          GPIO_REG_EDGE_CAP: regVal = mCap;
          GPIO_REG_DOUT_RB:  regVal = mDout;
          default:           regVal = '0;
        endcase
        irqNext = (mCap & mMask) != '0;
        riseNow = dinAfter(edgeNo - 1) & ~dinAfter(edgeNo - 2);
        clr     = (bus.Write && bus.Address == GPIO_REG_EDGE_CAP) ? bus.WriteData : '0;
        if (bus.Write) begin
          if (bus.Address == GPIO_REG_DATA || bus.Address == GPIO_REG_DOUT_RB) mDout = bus.WriteData;
          if (bus.Address == GPIO_REG_DIR)      mDir  = bus.WriteData;
          if (bus.Address == GPIO_REG_IRQ_MASK) mMask = bus.WriteData;
        end
        mCap     = (mCap & ~clr) | riseNow;
        mIrq     = irqNext;
        mRdValid = bus.Read;
        if (bus.Read) mRdData = regVal;
      end
      edgeNo++;
    end
  end

  // ---------------- checking ----------------
  task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                             input logic [WIDTH-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle, just after the edge, hold the DUT against the model.
  initial begin : compareProc
    logic [WIDTH-1:0] known;
    forever begin
      @(posedge clock);
      #1;
      if (ModelOn) begin
        known = mDir | tbEn;
        checkOutput("model ReadValid", {31'd0, bus.ReadValid}, {31'd0, mRdValid});
        checkOutput("model ReadData", bus.ReadData, mRdData);
        checkOutput("model IRQ", {31'd0, irq}, {31'd0, mIrq});
        checkOutput("model GPIO", gpio & known, pinsNow() & known);
      end
    end
  end

  // One bus cycle, issued at a falling edge and retired at the next one.
  task automatic applyStimulus(input logic wr, input logic rd, input gpio_addr_t addr,
                               input logic [WIDTH-1:0] data);
    bus.Write     = wr;
    bus.Read      = rd;
    bus.Address   = addr;
    bus.WriteData = data;
    @(negedge clock);
    bus.Write = 1'b0;
    bus.Read  = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected end of sequence");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    reset         = 1'b1;
    bus.Write     = 1'b0;
    bus.Read      = 1'b0;
    bus.Address   = '0;
    bus.WriteData = '0;
    tbOut         = '0;
    tbEn          = '1;
    repeat (2) @(negedge clock);
    checkOutput("reset IRQ", {31'd0, irq}, 32'd0);
    checkOutput("reset ReadValid", {31'd0, bus.ReadValid}, 32'd0);
    checkOutput("reset ReadData", bus.ReadData, 32'd0);
    reset = 1'b0;

`ifdef GPIO_DEBOUNCE_EN
    // 3-cycle glitch on pin 3 must be filtered out.
    tbOut = 32'h0000_0008;
    repeat (3) @(negedge clock);
    tbOut = '0;
    repeat (12) @(negedge clock);
    applyStimulus(1'b0, 1'b1, GPIO_REG_EDGE_CAP, '0);
    checkOutput("debounce short pulse", bus.ReadData, 32'h0000_0000);
    // A 6-cycle high passes the 4-cycle filter and is captured.
    tbOut = 32'h0000_0008;
    repeat (6) @(negedge clock);
    repeat (10) @(negedge clock);
    applyStimulus(1'b0, 1'b1, GPIO_REG_EDGE_CAP, '0);
    checkOutput("debounce long pulse", bus.ReadData, 32'h0000_0008);
`else
    // Reset values through the bus.
    applyStimulus(1'b0, 1'b1, GPIO_REG_DIR, '0);
    checkOutput("DIR after reset", bus.ReadData, 32'h0);
    checkOutput("ReadValid pulse", {31'd0, bus.ReadValid}, 32'd1);
    @(negedge clock);
    checkOutput("ReadValid drops", {31'd0, bus.ReadValid}, 32'd0);

    // Drive the low byte.
    tbEn = ~32'h0000_00FF;
    applyStimulus(1'b1, 1'b0, GPIO_REG_DIR, 32'h0000_00FF);
    applyStimulus(1'b1, 1'b0, GPIO_REG_DATA, 32'h0000_00A5);
    checkOutput("drive pins", gpio, 32'h0000_00A5);
    applyStimulus(1'b0, 1'b1, GPIO_REG_DOUT_RB, '0);
    checkOutput("DOUT_RB readback", bus.ReadData, 32'h0000_00A5);

    // Release the pins and sample a bench-driven pattern.
    applyStimulus(1'b1, 1'b0, GPIO_REG_DIR, 32'h0);
    tbEn  = '1;
    tbOut = 32'h1234_5678;
    repeat (2) @(negedge clock);
    applyStimulus(1'b0, 1'b1, GPIO_REG_DATA, '0);
    checkOutput("DATA input sample", bus.ReadData, 32'h1234_5678);
    applyStimulus(1'b1, 1'b0, GPIO_REG_EDGE_CAP, '1);
    applyStimulus(1'b0, 1'b1, GPIO_REG_EDGE_CAP, '0);
    checkOutput("EDGE_CAP cleared", bus.ReadData, 32'h0);

    // Rising pin 0 reaches IRQ after exactly four edges.
    applyStimulus(1'b1, 1'b0, GPIO_REG_IRQ_MASK, 32'h1);
    tbOut = 32'h1234_5679;
    repeat (3) @(negedge clock);
    checkOutput("IRQ not before 4 cycles", {31'd0, irq}, 32'd0);
    @(negedge clock);
    checkOutput("IRQ at 4 cycles", {31'd0, irq}, 32'd1);

    // Write-1-to-clear drops IRQ the cycle after next.
    applyStimulus(1'b1, 1'b0, GPIO_REG_EDGE_CAP, 32'h1);
    checkOutput("IRQ still high after clear", {31'd0, irq}, 32'd1);
    @(negedge clock);
    checkOutput("IRQ low after clear", {31'd0, irq}, 32'd0);

    // Clear landing on the same edge as a new rise: set wins.
    tbOut = 32'h1234_5678;
    repeat (4) @(negedge clock);
    tbOut = 32'h1234_5679;
    repeat (2) @(negedge clock);
    applyStimulus(1'b1, 1'b0, GPIO_REG_EDGE_CAP, 32'h1);
    applyStimulus(1'b0, 1'b1, GPIO_REG_EDGE_CAP, '0);
    checkOutput("set wins over clear", bus.ReadData, 32'h1);

    // Read and write of the same register in one cycle.
    applyStimulus(1'b1, 1'b0, GPIO_REG_IRQ_MASK, 32'h0F);
    applyStimulus(1'b1, 1'b1, GPIO_REG_IRQ_MASK, 32'hF0);
    checkOutput("collision old value", bus.ReadData, 32'h0F);
    applyStimulus(1'b0, 1'b1, GPIO_REG_IRQ_MASK, '0);
    checkOutput("collision new value", bus.ReadData, 32'hF0);

    // Unmapped address, then back-to-back reads.
    applyStimulus(1'b1, 1'b0, 3'd6, '1);
    applyStimulus(1'b0, 1'b1, 3'd6, '0);
    checkOutput("addr 6 reads zero", bus.ReadData, 32'h0);
    applyStimulus(1'b0, 1'b1, GPIO_REG_DOUT_RB, '0);
    applyStimulus(1'b0, 1'b1, GPIO_REG_IRQ_MASK, '0);
    checkOutput("back-to-back second read", bus.ReadData, 32'hF0);

    // Reset during a read: no ReadValid, then pins already high are
    // captured once after release.
    reset       = 1'b1;
    bus.Read    = 1'b1;
    bus.Address = GPIO_REG_DOUT_RB;
    @(negedge clock);
    bus.Read = 1'b0;
    checkOutput("reset aborts read", {31'd0, bus.ReadValid}, 32'd0);
    checkOutput("reset clears ReadData", bus.ReadData, 32'h0);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    applyStimulus(1'b0, 1'b1, GPIO_REG_EDGE_CAP, '0);
    checkOutput("capture after reset", bus.ReadData, 32'h1234_5679);
    checkOutput("IRQ masked after reset", {31'd0, irq}, 32'd0);
`endif

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_port_ctrl.md
# gpio_port_ctrl

Register-mapped controller for the 32-bit DE-series GPIO header. It owns the tri-state drive of every header pin through per-bit direction and data-out registers, and synchronizes the pin inputs. Rising edges on the inputs are captured into sticky bits that can raise an interrupt. It sits between a simple single-master register bus (processor or test sequencer) and the top-level `GPIO` inout, replacing hard-wired `Z` assignments.

## Interface
- `WIDTH`, 32: number of header pins controlled.
- `DEBOUNCE_CYCLES`, 16: stable-sample count for the optional debounce filter (≥1).
- `CLOCK_50` in 1: sole clock; all state on rising edge.
- `Reset` in 1: synchronous, active-high.
- `Address` in 3: register select.
- `Write` in 1: write strobe, one cycle per access.
- `WriteData` in WIDTH: write data.
- `Read` in 1: read strobe, one cycle per access.
- `ReadData` out WIDTH: read result.
- `ReadValid` out 1: `ReadData` valid this cycle.
- `IRQ` out 1: level interrupt.
- `GPIO` inout WIDTH: header pins.

## Operation
- Registers:
  - 0 DATA: write sets `dout`; read returns filtered input `din_f` for all bits, output or not.
  - 1 DIR: 1 = drive pin, 0 = Z.
  - 2 IRQ_MASK: per-bit interrupt enable.
  - 3 EDGE_CAP: read returns sticky capture; write-1-to-clear.
  - 4 DOUT_RB: read returns `dout`; write is equivalent to DATA.
  - 5–7: reads return 0, writes ignored.
- Pin drive: `GPIO[i] = DIR[i] ? dout[i] : 1'bz`.
- Input path per bit: 2-flop synchronizer → `din_s`; `din_f = din_s` (or debounced, see Configuration); `din_prev` holds the last `din_f`.
- Edge: `rise[i] = din_f[i] & ~din_prev[i]`. `EDGE_CAP[i]` is set on `rise[i]`.
- `IRQ = |(EDGE_CAP & IRQ_MASK)`, registered.
- Simultaneous events:
  - W1C clear and new `rise` on the same bit in the same cycle: the bit stays set (set wins).
  - `Read` and `Write` in the same cycle: both are performed. Read returns the pre-write value.
  - Writing DIR 0→1 drives the current `dout` in the next cycle. No glitch to a stale value.
- Reset clears everything: `dout`, DIR, IRQ_MASK, EDGE_CAP, `din_s`, `din_prev`, and debounce state all go to 0. Result: all pins Z, `ReadData=0`, `ReadValid=0`, `IRQ=0`. Reset asserted mid-access aborts the access and no `ReadValid` follows. `din_prev` reloads from 0, so pins already high produce one capture after reset release plus the sync latency.

## Timing
- Write: takes effect at the clock edge where `Write=1`. The pin changes in the following cycle.
- Read: latency 1. `ReadValid` pulses one cycle after `Read`. `ReadData` holds until the next read.
- Pin to `din_s`: 2 cycles. `din_s` to `EDGE_CAP`: 1 cycle (no debounce). `EDGE_CAP` to `IRQ`: 1 cycle.
- Total pin rise to `IRQ` = 4 cycles (no debounce).
- Back-to-back reads every cycle are supported.

## Configuration
- `GPIO_DEBOUNCE_EN` defined:
  - Each bit has a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - `din_f[i]` takes `din_s[i]` only after `din_s[i]` differs from `din_f[i]` for `DEBOUNCE_CYCLES` consecutive cycles.
  - Any return to the `din_f` value resets the counter to 0.
  - This adds `DEBOUNCE_CYCLES` cycles of input latency.
- Undefined: `din_f = din_s` and no counters are instantiated.

## Structure
- Shared package `gpio_pkg`:
  - Register address constants `GPIO_REG_DATA`…`GPIO_REG_DOUT_RB`.
  - `gpio_addr_t` (3-bit) typedef.
- Sub-module `gpio_sync_debounce` (one bit; synchronizer plus optional debounce), instantiated WIDTH times via generate.
- Register file, edge logic, and tri-state stay in `gpio_port_ctrl`.

## Test plan
- **Reset:** assert `Reset` 2 cycles → `GPIO` all Z, `IRQ=0`. Read addr 1 → `ReadData=0`, `ReadValid` one cycle later.
- **Drive:** write DIR=`0x000000FF`, DATA=`0x000000A5` → `GPIO[7:0]=8'hA5` the next cycle, `GPIO[31:8]`=Z. Read addr 4 → `0x000000A5`.
- **Input sampling:** DIR=0, bench drives `GPIO=0x12345678` → read DATA ≥2 cycles later returns `0x12345678`.
- **Interrupt:**
  - IRQ_MASK=`0x1`, bench raises `GPIO[0]` → `IRQ=1` exactly 4 cycles later.
  - Write EDGE_CAP=`0x1` → `IRQ=0` the cycle after next.
  - Repeat with the clear landing on the same cycle as a new rise → bit stays 1.
- **Read/Write collision and invalid address:**
  - Same-cycle Read+Write of addr 2 with `0xF0` over `0x0F` → `ReadData=0x0F`, subsequent read `0xF0`.
  - Addr 6 read → 0.
- **Debounce (`GPIO_DEBOUNCE_EN`, `DEBOUNCE_CYCLES=4`):**
  - 3-cycle pulse on `GPIO[3]` → no capture.
  - 6-cycle high → `EDGE_CAP[3]=1`.
